// File: rtl/fpu_pkg.sv
// Shared constants and the result record for the FPU significand add path.
package fpu_pkg;

    localparam int FPU_SIG_W     = 48;
    // Widest significand the result record can hold; narrower instances zero-extend.
    localparam int FPU_SIG_W_MAX = 64;

    typedef struct packed {
        logic [FPU_SIG_W_MAX:0] sum;
        logic                   sign;
        logic                   g;
        logic                   r;
        logic                   s;
        logic                   carry;
        logic                   zero;
    } fpu_add_res_t;

endpackage

// File: rtl/fpu_adder_pipe_slice.sv
// Parametrised-width ripple adder slice with carry-in and carry-out.
module fpu_add_slice #(
    parameter int W = 24
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co
);

    assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};

endmodule

// File: rtl/fpu_adder_pipe.sv
// Two-stage significand adder/subtractor: low halves in stage 1, high halves,
// result selection and flag derivation in stage 2, with valid/ready flow control.
module fpu_adder_pipe
    import fpu_pkg::*;
#(
    parameter int SIG_W = FPU_SIG_W,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] in_a,
    input  logic [SIG_W-1:0] in_b,
    input  logic             in_eff_sub,
    input  logic             in_sticky,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W:0]   out_sum,
    output logic             out_sign,
    output logic             out_guard,
    output logic             out_round,
    output logic             out_sticky,
    output logic             out_carry,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LO_W = SIG_W / 2;
    localparam int HI_W = SIG_W - LO_W;

    logic             w_s1_load, w_s2_load;
    logic [LO_W-1:0]  w_a_lo, w_b_lo, w_lo_add, w_lo_ab, w_lo_ba;
    logic             w_lo_add_c, w_lo_ab_c, w_lo_ba_c;
    logic [HI_W-1:0]  w_hi_add, w_hi_ab, w_hi_ba;
    logic             w_hi_add_c, w_hi_ab_c, w_hi_ba_c;
    fpu_add_res_t     w_res;

    logic             r_s1_valid, r_s1_eff_sub, r_s1_sticky;
    logic [LO_W-1:0]  r_s1_add_lo, r_s1_ab_lo, r_s1_ba_lo;
    logic             r_s1_add_c, r_s1_ab_c, r_s1_ba_c;
    logic [HI_W-1:0]  r_s1_a_hi, r_s1_b_hi;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid, r_s2_sign, r_s2_g, r_s2_r, r_s2_s, r_s2_carry, r_s2_zero;
    logic [SIG_W:0]   r_s2_sum;
    logic [TAG_W-1:0] r_s2_tag;

    assign w_s2_load = !r_s2_valid | out_ready;
    assign w_s1_load = !r_s1_valid | w_s2_load;
    assign in_ready  = w_s1_load;

    assign w_a_lo = in_a[LO_W-1:0];
    assign w_b_lo = in_b[LO_W-1:0];

    // Subtraction is A + ~B + 1; a carry-out of the A-B chain means no borrow (A >= B).
    fpu_add_slice #(.W(LO_W)) u_lo_add (.i_a(w_a_lo), .i_b(w_b_lo),  .i_ci(1'b0), .o_s(w_lo_add), .o_co(w_lo_add_c));
    fpu_add_slice #(.W(LO_W)) u_lo_ab  (.i_a(w_a_lo), .i_b(~w_b_lo), .i_ci(1'b1), .o_s(w_lo_ab),  .o_co(w_lo_ab_c));
    fpu_add_slice #(.W(LO_W)) u_lo_ba  (.i_a(w_b_lo), .i_b(~w_a_lo), .i_ci(1'b1), .o_s(w_lo_ba),  .o_co(w_lo_ba_c));

    fpu_add_slice #(.W(HI_W)) u_hi_add (.i_a(r_s1_a_hi), .i_b(r_s1_b_hi),  .i_ci(r_s1_add_c), .o_s(w_hi_add), .o_co(w_hi_add_c));
    fpu_add_slice #(.W(HI_W)) u_hi_ab  (.i_a(r_s1_a_hi), .i_b(~r_s1_b_hi), .i_ci(r_s1_ab_c),  .o_s(w_hi_ab),  .o_co(w_hi_ab_c));
    fpu_add_slice #(.W(HI_W)) u_hi_ba  (.i_a(r_s1_b_hi), .i_b(~r_s1_a_hi), .i_ci(r_s1_ba_c),  .o_s(w_hi_ba),  .o_co(w_hi_ba_c));

    // Stage 1 register: low-half partial sums plus the operands' high halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_add_lo  <= '0;
            r_s1_ab_lo   <= '0;
            r_s1_ba_lo   <= '0;
            r_s1_add_c   <= 1'b0;
            r_s1_ab_c    <= 1'b0;
            r_s1_ba_c    <= 1'b0;
            r_s1_a_hi    <= '0;
            r_s1_b_hi    <= '0;
            r_s1_eff_sub <= 1'b0;
            r_s1_sticky  <= 1'b0;
            r_s1_tag     <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_add_lo  <= w_lo_add;
                r_s1_ab_lo   <= w_lo_ab;
                r_s1_ba_lo   <= w_lo_ba;
                r_s1_add_c   <= w_lo_add_c;
                r_s1_ab_c    <= w_lo_ab_c;
                r_s1_ba_c    <= w_lo_ba_c;
                r_s1_a_hi    <= in_a[SIG_W-1:LO_W];
                r_s1_b_hi    <= in_b[SIG_W-1:LO_W];
                r_s1_eff_sub <= in_eff_sub;
                r_s1_sticky  <= in_sticky;
                r_s1_tag     <= in_tag;
            end
        end
    end

    // Stage 2 combinational: pick the result by operation and A-B borrow, derive flags.
    always_comb begin
        w_res = '0;
        if (!r_s1_eff_sub) begin
            w_res.sum[SIG_W:0] = {w_hi_add_c, w_hi_add, r_s1_add_lo};
            w_res.sign         = 1'b0;
        end else if (w_hi_ab_c) begin
            w_res.sum[SIG_W:0] = {1'b0, w_hi_ab, r_s1_ab_lo};
            w_res.sign         = 1'b0;
        end else begin
            w_res.sum[SIG_W:0] = {1'b0, w_hi_ba, r_s1_ba_lo};
            w_res.sign         = 1'b1;
        end
        w_res.g     = w_res.sum[2];
        w_res.r     = w_res.sum[1];
        w_res.s     = w_res.sum[0] | r_s1_sticky;
        w_res.carry = !r_s1_eff_sub & w_res.sum[SIG_W];
        w_res.zero  = (w_res.sum == '0);
    end

    // Stage 2 register: drives every output directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_sign  <= 1'b0;
            r_s2_g     <= 1'b0;
            r_s2_r     <= 1'b0;
            r_s2_s     <= 1'b0;
            r_s2_carry <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sum   <= w_res.sum[SIG_W:0];
                r_s2_sign  <= w_res.sign;
                r_s2_g     <= w_res.g;
                r_s2_r     <= w_res.r;
                r_s2_s     <= w_res.s;
                r_s2_carry <= w_res.carry;
                r_s2_zero  <= w_res.zero;
                r_s2_tag   <= r_s1_tag;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_sum    = r_s2_sum;
    assign out_sign   = r_s2_sign;
    assign out_guard  = r_s2_g;
    assign out_round  = r_s2_r;
    assign out_sticky = r_s2_s;
    assign out_carry  = r_s2_carry;
    assign out_zero   = r_s2_zero;
    assign out_tag    = r_s2_tag;

endmodule

// File: tb/tb_fpu_adder_pipe.sv
// Directed bench for fpu_adder_pipe: 48-bit instance plus an 8-bit instance.
module tb_fpu_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_eff_sub, in_sticky;
    logic [47:0] in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic        out_valid, out_ready;
    logic [48:0] out_sum;
    logic        out_sign, out_guard, out_round, out_sticky, out_carry, out_zero;

    logic        n_in_valid, n_in_ready, n_out_valid;
    logic [7:0]  n_in_a, n_in_b;
    logic [3:0]  n_out_tag;
    logic [8:0]  n_out_sum;
    logic        n_out_sign, n_out_guard, n_out_round, n_out_sticky, n_out_carry, n_out_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fpu_adder_pipe #(.SIG_W(48), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_eff_sub(in_eff_sub), .in_sticky(in_sticky), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_sign(out_sign), .out_guard(out_guard), .out_round(out_round),
        .out_sticky(out_sticky), .out_carry(out_carry), .out_zero(out_zero),
        .out_tag(out_tag)
    );

    fpu_adder_pipe #(.SIG_W(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_a(n_in_a), .in_b(n_in_b),
        .in_eff_sub(1'b1), .in_sticky(1'b0), .in_tag(4'h3),
        .out_valid(n_out_valid), .out_ready(1'b1), .out_sum(n_out_sum),
        .out_sign(n_out_sign), .out_guard(n_out_guard), .out_round(n_out_round),
        .out_sticky(n_out_sticky), .out_carry(n_out_carry), .out_zero(n_out_zero),
        .out_tag(n_out_tag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one op with out_ready high and leaves the bench two edges later.
    task automatic issue_op(input logic [47:0] a, input logic [47:0] b,
                            input logic sub, input logic stk, input logic [3:0] tag);
        in_valid = 1'b1; in_a = a; in_b = b; in_eff_sub = sub; in_sticky = stk; in_tag = tag;
        #1;
        chk("accept_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("lat_edge1", {63'd0, out_valid}, 64'd0);
        tick();
        chk("lat_edge2", {63'd0, out_valid}, 64'd1);
        chk("op_tag", {60'd0, out_tag}, {60'd0, tag});
    endtask

    int          sent, rcv;
    logic        hold_v, seen_low;
    logic [48:0] hold_sum;
    logic [3:0]  hold_tag;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_eff_sub = 1'b0;
        in_sticky = 1'b0; in_tag = '0; out_ready = 1'b1;
        n_in_valid = 1'b0; n_in_a = '0; n_in_b = '0;
        tick(); tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {15'd0, out_sum}, 64'd0);
        chk("rst_zero", {63'd0, out_zero}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        tick();

        // Addition with carry-out
        issue_op(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 4'h1);
        chk("add_sum", {15'd0, out_sum}, 64'h1_0000_0000_0000);
        chk("add_carry", {63'd0, out_carry}, 64'd1);
        chk("add_zero", {63'd0, out_zero}, 64'd0);
        chk("add_sign", {63'd0, out_sign}, 64'd0);
        tick();
        chk("add_retired", {63'd0, out_valid}, 64'd0);

        // Subtraction with sign flip
        issue_op(48'h1, 48'h8000_0000_0000, 1'b1, 1'b0, 4'h2);
        chk("subneg_sum", {15'd0, out_sum}, 64'h7FFF_FFFF_FFFF);
        chk("subneg_sign", {63'd0, out_sign}, 64'd1);
        chk("subneg_grs", {61'd0, out_guard, out_round, out_sticky}, 64'd7);
        chk("subneg_carry", {63'd0, out_carry}, 64'd0);
        tick();

        // Equal operands with incoming sticky
        issue_op(48'hABCD_EF12_3456, 48'hABCD_EF12_3456, 1'b1, 1'b1, 4'h3);
        chk("eq_sum", {15'd0, out_sum}, 64'd0);
        chk("eq_sign", {63'd0, out_sign}, 64'd0);
        chk("eq_zero", {63'd0, out_zero}, 64'd1);
        chk("eq_grs", {61'd0, out_guard, out_round, out_sticky}, 64'd1);
        tick();

        // Subtraction A > B without carry
        issue_op(48'h10, 48'h3, 1'b1, 1'b0, 4'h4);
        chk("subpos_sum", {15'd0, out_sum}, 64'hD);
        chk("subpos_sign", {63'd0, out_sign}, 64'd0);
        chk("subpos_grs", {61'd0, out_guard, out_round, out_sticky}, 64'd5);
        chk("subpos_carry", {63'd0, out_carry}, 64'd0);
        tick();

        // Back-to-back stream of 8 with out_ready low during cycles 3..6
        sent = 0; rcv = 0; hold_v = 1'b0; seen_low = 1'b0; hold_sum = '0; hold_tag = '0;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            in_valid   = (sent < 8);
            in_a       = 48'(sent) * 48'h10 + 48'h5;
            in_b       = 48'h3;
            in_eff_sub = 1'b0;
            in_sticky  = 1'b0;
            in_tag     = 4'(sent);
            out_ready  = !(c >= 3 && c <= 6);
            #1;
            if (hold_v) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_sum", {15'd0, out_sum}, {15'd0, hold_sum});
                chk("stall_tag", {60'd0, out_tag}, {60'd0, hold_tag});
            end
            if (!in_ready) begin
                seen_low = 1'b1;
                chk("ready_low_depth", 64'(sent - rcv), 64'd2);
            end
            if (out_valid && out_ready) begin
                chk("stream_tag", {60'd0, out_tag}, 64'(rcv));
                chk("stream_sum", {15'd0, out_sum}, 64'(rcv) * 64'd16 + 64'd8);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            hold_v   = out_valid & !out_ready;
            hold_sum = out_sum;
            hold_tag = out_tag;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 64'(rcv), 64'd8);
        chk("stream_ready_dropped", {63'd0, seen_low}, 64'd1);
        tick();
        chk("stream_no_dup", {63'd0, out_valid}, 64'd0);

        // Reset with two ops held in the pipe
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 48'h77; in_b = 48'h11; in_eff_sub = 1'b0; in_tag = 4'h9;
        tick();
        in_tag = 4'hA;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_sum", {15'd0, out_sum}, 64'd0);
        chk("mrst_tag", {60'd0, out_tag}, 64'd0);
        chk("mrst_flags", {58'd0, out_sign, out_guard, out_round, out_sticky, out_carry, out_zero}, 64'd0);
        chk("mrst_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        tick();
        chk("mrst_drop1", {63'd0, out_valid}, 64'd0);
        tick();
        chk("mrst_drop2", {63'd0, out_valid}, 64'd0);
        issue_op(48'h20, 48'h2, 1'b0, 1'b0, 4'h5);
        chk("post_rst_sum", {15'd0, out_sum}, 64'h22);
        tick();

        // Narrow instance: 5 - 10
        n_in_valid = 1'b1; n_in_a = 8'h05; n_in_b = 8'h0A;
        tick();
        n_in_valid = 1'b0;
        chk("n_lat1", {63'd0, n_out_valid}, 64'd0);
        tick();
        chk("n_lat2", {63'd0, n_out_valid}, 64'd1);
        chk("n_sum", {55'd0, n_out_sum}, 64'h005);
        chk("n_sign", {63'd0, n_out_sign}, 64'd1);
        chk("n_grs", {61'd0, n_out_guard, n_out_round, n_out_sticky}, 64'd5);
        chk("n_tag_carry", {59'd0, n_out_tag, n_out_carry}, 64'h6);
        chk("n_zero_ready", {62'd0, n_out_zero, n_in_ready}, 64'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_adder_pipe.md
# fpu_adder_pipe

Pipelined, parametrised significand adder/subtractor for the FPU add path, sitting between the alignment shifter and the normaliser. It produces the magnitude of A±B (swapping on negative difference), the result sign, guard/round/sticky bits and carry/zero flags. It is split into two register stages with valid/ready flow control and a pass-through tag. It is the multi-cycle, back-pressurable replacement for the single-cycle combinational `fpu_adder`.

## Interface
- `SIG_W`, 48: significand operand width (even, ≥ 8); the result is `SIG_W+1` bits.
- `TAG_W`, 4: width of the opaque tag carried alongside each operation.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input operation present.
- `in_ready`  out  1  block accepts the input this cycle.
- `in_a`  in  SIG_W  aligned significand A.
- `in_b`  in  SIG_W  aligned significand B.
- `in_eff_sub`  in  1  1 = effective subtraction A−B; 0 = A+B.
- `in_sticky`  in  1  sticky from the alignment shift.
- `in_tag`  in  TAG_W  opaque tag.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  SIG_W+1  result magnitude.
- `out_sign`  out  1  1 when A−B is negative.
- `out_guard` / `out_round` / `out_sticky`  out  1 each  equal to `out_sum[2]`, `out_sum[1]`, and `out_sum[0] | sticky`, respectively.
- `out_carry`  out  1  `out_sum[SIG_W]` on addition; always 0 on subtraction.
- `out_zero`  out  1  `out_sum == 0`; independent of sticky.
- `out_tag`  out  TAG_W  tag of the operation.

## Operation
- **Add:** `sum = {0,A} + {0,B}`; `sign = 0`.
- **Sub, A ≥ B:** `sum = A − B`; `sign = 0`.
- **Sub, A < B:** `sum = B − A`; `sign = 1`.
- **Sub, A == B:** `sum = 0`; `sign = 0`.
- Both subtraction orders are computed in parallel; no comparator precedes the adder. The selection uses the borrow-out of A−B.
- Let `LO_W = SIG_W/2`.
- **Stage 1** registers:
  - the low `LO_W` bits of A+B, A−B and B−A, each with its carry/borrow out;
  - the high halves of A and B;
  - `eff_sub`, `sticky` and `tag`.
- **Stage 2** registers:
  - completes the high halves using the stage-1 carries;
  - selects the result by `eff_sub` and the A−B borrow;
  - derives sign, GRS, carry and zero.
- Outputs are driven directly from the stage-2 registers; there is no combinational logic after the last flop.
- **Reset:** both stage valids go to 0 and all data registers clear. All outputs read 0, and `in_ready` reads 1 while `rst` is low and the pipe is empty. Operations in flight when `rst` is asserted are discarded with no output.

## Timing
- **Latency:** an input accepted at edge N (`in_valid & in_ready`) is shown with `out_valid = 1` after edge N+2, when there is no stall.
- **Throughput:** one operation per cycle while `out_ready` stays high.
- **Advance conditions:**
  - stage 2 loads when `!s2_valid | out_ready`;
  - stage 1 loads when `!s1_valid | s2_load`;
  - `in_ready = !s1_valid | s2_load`, a combinational path from `out_ready`.
- **Stall:** while `out_valid & !out_ready`, every output holds stable, nothing is lost or duplicated, and the pipe fills to 2 entries before `in_ready` drops.
- **Bubbles** propagate; they never produce `out_valid`.
- **Simultaneous accept and retire:** when stage 2 retires an entry in the same cycle stage 1 receives a new one, both happen; ordering is strictly FIFO.

## Structure
- Package `fpu_pkg` holds:
  - the `SIG_W` default constant;
  - a packed `fpu_add_res_t` containing sum, sign, g, r, s, carry, zero.
- One sub-module, `fpu_add_slice`: a parametrised-width adder taking a carry-in and producing a carry-out. It is instantiated for the low and high halves of each of the three sums.
- The two pipeline stages live in the top module.

## Test plan
- **Addition with carry:** A=0xFFFFFFFFFFFF, B=1, add. Expect sum=0x1000000000000, carry=1, zero=0, sign=0, and out_valid exactly 2 cycles after acceptance.
- **Subtraction with sign flip:** A=1, B=0x800000000000, sub. Expect sum=0x7FFFFFFFFFFF, sign=1, G=R=S=1, carry=0.
- **Equal operands with sticky:** A=B=0xABCDEF123456, sub, sticky=1. Expect sum=0, sign=0, zero=1, sticky=1.
- **Back-to-back stream with stall:** drive 8 back-to-back operations with tags 0–7 while holding `out_ready=0` for cycles 3–6. Expect results in tag order, no drops, `in_ready` low only after 2 entries are held, and outputs stable during the stall.
- **Reset mid-stream:** assert `rst` for 1 cycle with 2 operations in flight. Expect no `out_valid` for those operations, all outputs 0, and the next input to complete normally with latency 2.
- **Narrow parameterisation:** `SIG_W=8`, A=0x05, B=0x0A, sub. Expect sum=0x005, sign=1, G=1, R=0, S=1.
